pe_left_feeder: RTL
===================

# pe_left_feeder

Skewing transmitter for the left edge of a systolic PE array. It accepts one column vector of ROWS unsigned 12-bit activations per beat over a valid/ready handshake and drives the array's left-edge inputs with a diagonal skew: row r lags row 0 by r advances. It also generates the array-wide `pe_en`, so the array and the skew chain advance in lockstep. After a tile's last beat it flushes zeros until the skew triangle drains. It sits between the activation buffer reader and the row-0 column of PEs.

## Interface
- ROWS, 4, number of array rows (≥2)
- DATA_W, 12, activation width per row
- LEN_W, 16, width of beat-count field
- clk  in  1  clock
- reset  in  1  reset; synchronous, active-high
- start  in  1  one-cycle tile start pulse; honoured only in IDLE
- k_len  in  LEN_W  beats in tile; latched on accepted `start`
- s_valid  in  1  upstream beat valid
- s_ready  out  1  feeder can accept beat
- s_data  in  ROWS*DATA_W  lane r = bits [r*DATA_W +: DATA_W] → row r
- left_out  out  ROWS*DATA_W  lane r drives row r PE `left`
- pe_en  out  1  array advance enable
- busy  out  1  state ≠ IDLE
- tile_done  out  1  one-cycle pulse at tile end

## Operation
- Skew chain: row r is a shift register of r+1 stages, DATA_W bits each. Stage 0 loads from `s_data` lane r, or from zero during FLUSH. `left_out` lane r is row r's last stage.
- advance = (STREAM & s_valid) | FLUSH. On advance, all stages shift. Otherwise all stages hold.
- pe_en = advance. It is combinational from state and `s_valid` and drives the same edge that shifts the chain.
- s_ready = (state == STREAM). It is combinational and does not depend on `s_valid`.
- FSM states:
  - IDLE: on `start` with k_len>0 → STREAM, cnt ← k_len. On `start` with k_len=0 → stay IDLE, pulse tile_done next cycle.
  - STREAM: on each accepted beat, cnt ← cnt−1. When the beat with cnt=1 is accepted → FLUSH, fcnt ← ROWS.
  - FLUSH: inject zero into every row's stage 0, pe_en=1. Decrement fcnt each cycle. When fcnt=1 → IDLE, and assert tile_done in the following cycle.
- `start` outside IDLE is ignored. k_len is not re-sampled.
- No arithmetic on data. Values pass unchanged (unsigned, zero-extended nowhere).
- Chain contents persist after a tile. In IDLE they hold and `left_out` is not cleared, except by reset.

## Timing
- Reset values: every chain stage 0, so left_out=0. State IDLE, cnt=0, fcnt=0, s_ready=0, pe_en=0, busy=0, tile_done=0.
- A beat accepted at edge t appears on lane 0 after edge t. Lane r shows it after r further advances.
- The PE in row r captures beat i at the (i+r+1)-th advance edge of the tile.
- Tile duration in advance cycles = k_len + ROWS. Stall cycles, where `s_valid` is low in STREAM, freeze both the chain and the array with no loss.
- tile_done is registered: high exactly one cycle, the cycle after the last FLUSH cycle, with state already IDLE. busy is low in that cycle.
- A `start` in the tile_done cycle is accepted: back-to-back tiles.
- Reset mid-tile: next cycle matches reset values exactly. No tile_done is issued.

## Configuration
- PE_FEEDER_STALL_CNT_EN defined:
  - Adds output `stall_cycles` (32 bits).
  - Counts STREAM cycles with s_valid=0.
  - Cleared to 0 on accepted `start` and on reset.
  - Saturates at all-ones.
  - Holds its value in IDLE.
- Not defined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Reset, then idle 5 cycles → left_out=0, pe_en=0, s_ready=0, busy=0, tile_done=0 throughout.
- ROWS=4, start k_len=3, s_valid held high, lanes = beat index+1 (beat i: all lanes = i+1) → pe_en high exactly 7 consecutive cycles. Lane 0 sequence 1,2,3,0. Lane 3 first shows 1 after the 4th advance. tile_done one cycle after the 7th pe_en.
- Same tile with s_valid low for 2 cycles between beats 1 and 2 → pe_en low those 2 cycles, left_out frozen, final lane values identical to the previous scenario. stall_cycles=2 with PE_FEEDER_STALL_CNT_EN.
- start with k_len=0 → tile_done next cycle, pe_en never asserted, busy stays 0. start pulsed during STREAM → ignored, beat count unchanged.
- Reset asserted in FLUSH cycle 2 → all outputs at reset values next cycle, no tile_done. A new start with k_len=1 then completes in 1+4 advances.
- Back-to-back: second start in the tile_done cycle, k_len=2 → s_ready high the next cycle, no extra idle gap.

Source files
------------

// File: rtl/pe_left_feeder.sv
`default_nettype none
// ============================================================================
// pe_left_feeder : diagonal-skew activation feeder and pe_en generator for the
//                  left edge of a systolic PE array. Optional stall counter is
//                  enabled by defining PE_FEEDER_STALL_CNT_EN.
// Revision       : 1.0
// ============================================================================
module pe_left_feeder #(
  parameter int ROWS   = 4,
  parameter int DATA_W = 12,
  parameter int LEN_W  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [LEN_W-1:0]       k_len,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [ROWS*DATA_W-1:0] s_data,
  output logic [ROWS*DATA_W-1:0] left_out,
  output logic                   pe_en,
  output logic                   busy,
  output logic                   tile_done
`ifdef PE_FEEDER_STALL_CNT_EN
  ,
  output logic [31:0]            stall_cycles
`endif
);

  localparam int FCNT_W = $clog2(ROWS + 1);
  localparam logic [LEN_W-1:0]  c_CNT_ONE  = LEN_W'(1);
  localparam logic [FCNT_W-1:0] c_FCNT_ONE = FCNT_W'(1);
  localparam logic [FCNT_W-1:0] c_FCNT_INI = FCNT_W'(ROWS);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2
  } state_t;

  state_t            r_state;
  logic [LEN_W-1:0]  r_cnt;
  logic [FCNT_W-1:0] r_fcnt;
  logic              r_tile_done;

  logic w_advance;
  logic w_flush;

  assign w_flush   = (r_state == ST_FLUSH);
  assign w_advance = ((r_state == ST_STREAM) && s_valid) || w_flush;

  // pe_en must be the same signal that shifts the chain so array and skew stay aligned
  assign pe_en     = w_advance;
  assign s_ready   = (r_state == ST_STREAM);
  assign busy      = (r_state != ST_IDLE);
  assign tile_done = r_tile_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_fcnt      <= '0;
      r_tile_done <= 1'b0;
    end else begin
      r_tile_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (k_len != '0) begin
              r_state <= ST_STREAM;
              r_cnt   <= k_len;
            end else begin
              r_tile_done <= 1'b1;
            end
          end
        end
        ST_STREAM: begin
          if (s_valid) begin
            r_cnt <= r_cnt - c_CNT_ONE;
            if (r_cnt == c_CNT_ONE) begin
              r_state <= ST_FLUSH;
              r_fcnt  <= c_FCNT_INI;
            end
          end
        end
        ST_FLUSH: begin
          r_fcnt <= r_fcnt - c_FCNT_ONE;
          if (r_fcnt == c_FCNT_ONE) begin
            r_state     <= ST_IDLE;
            r_tile_done <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Row r is r+1 stages deep, producing the diagonal skew across rows
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [DATA_W-1:0] r_stage [0:r];

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int s = 0; s <= r; s++) begin
          r_stage[s] <= '0;
        end
      end else if (w_advance) begin
        r_stage[0] <= w_flush ? '0 : s_data[r*DATA_W +: DATA_W];
        for (int s = 1; s <= r; s++) begin
          r_stage[s] <= r_stage[s-1];
        end
      end
    end

    assign left_out[r*DATA_W +: DATA_W] = r_stage[r];
  end

`ifdef PE_FEEDER_STALL_CNT_EN
  logic [31:0] r_stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall <= '0;
    end else if ((r_state == ST_IDLE) && start) begin
      r_stall <= '0;
    end else if ((r_state == ST_STREAM) && !s_valid && (r_stall != '1)) begin
      r_stall <= r_stall + 32'd1;
    end
  end

  assign stall_cycles = r_stall;
`endif

endmodule
`default_nettype wire
